// File: rtl/datapath_trace_buffer.sv
// datapath_trace_buffer: circular capture of retired-instruction {pc, instruction, result} with a show-ahead read port
// Ports: clk/reset (sync, active-low); run gates capture; arm clears and arms, latching mode (0 stop-on-full, 1 wrap);
// cap_valid/pc/instruction/result capture one entry; rd_ready/rd_valid/rd_pc/rd_instr/rd_result drain the head;
// count/full/empty give occupancy; overflow is sticky on drop or overwrite; state is IDLE/ARMED/CAPTURE/DONE.
module datapath_trace_buffer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 17,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               arm,
  input  logic               mode,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [DATA_W-1:0]  result,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [DATA_W-1:0]  rd_result,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [1:0]         state
);
  localparam int E = PC_W + INSTR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} st_t;
  st_t st;
  logic [E-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic mode_l, fire, cap, wr, ovw, drop, pop;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_valid = ~empty;
  assign {rd_pc, rd_instr, rd_result} = mem[rptr];
  assign state = st;
  assign fire = rd_valid & rd_ready;
  assign cap = (st == CAPTURE) & run & cap_valid;
  // when full without a read, wrap mode overwrites the oldest entry, stop mode drops the capture
  assign ovw = cap & full & ~fire & mode_l;
  assign drop = cap & full & ~fire & ~mode_l;
  assign wr = cap & ~arm & ~drop;
  assign pop = fire | ovw;
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {pc, instruction, result};
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      mode_l <= 1'b0;
    end else if (arm) begin
      st <= ARMED;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      mode_l <= mode;
    end else begin
      wptr <= wptr + ADDR_W'(wr);
      rptr <= rptr + ADDR_W'(pop);
      count <= count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
      overflow <= overflow | ovw | drop;
      st <= (st == ARMED && run) ? CAPTURE :
            (st == CAPTURE && (!run || drop)) ? DONE : st;
    end
  end
endmodule

// File: tb/tb_datapath_trace_buffer.sv
// tb_datapath_trace_buffer: directed scoreboard bench for datapath_trace_buffer
module tb_datapath_trace_buffer;
  logic clk = 0, reset = 0, run = 0, arm = 0, mode = 0, cap_valid = 0, rd_ready = 0;
  logic [7:0] pc = 0, result = 0, rd_pc, rd_result;
  logic [16:0] instruction = 0, rd_instr;
  logic rd_valid, full, empty, overflow;
  logic [4:0] count;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  logic [32:0] q[$];
  int m_state = 0;
  bit m_mode = 0, m_ovf = 0;

  datapath_trace_buffer dut (
    .clk(clk), .reset(reset), .run(run), .arm(arm), .mode(mode), .cap_valid(cap_valid),
    .pc(pc), .instruction(instruction), .result(result), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    check("full", 32'(full), 32'(q.size() == 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("state", 32'(state), 32'(m_state));
  endtask

  task automatic cycle(input bit cv, input bit rr, input logic [7:0] p);
    bit fire, was_full;
    cap_valid = cv;
    rd_ready = rr;
    pc = p;
    instruction = {9'h155, p};
    result = p + 8'h90;
    fire = rr && q.size() != 0;
    was_full = q.size() == 16;
    if (fire) begin
      check("rd_pc", 32'(rd_pc), 32'(q[0][32:25]));
      check("rd_instr", 32'(rd_instr), 32'(q[0][24:8]));
      check("rd_result", 32'(rd_result), 32'(q[0][7:0]));
      void'(q.pop_front());
    end
    if (m_state == 2 && run && cv) begin
      if (!was_full || fire) q.push_back({pc, instruction, result});
      else if (!m_mode) begin m_ovf = 1; m_state = 3; end
      else begin void'(q.pop_front()); q.push_back({pc, instruction, result}); m_ovf = 1; end
    end
    if (m_state == 1 && run) m_state = 2;
    else if (m_state == 2 && !run) m_state = 3;
    @(posedge clk); #1;
    cap_valid = 0;
    rd_ready = 0;
    check_status();
  endtask

  task automatic do_arm(input bit m);
    arm = 1;
    mode = m;
    @(posedge clk); #1;
    arm = 0;
    q.delete();
    m_state = 1;
    m_mode = m;
    m_ovf = 0;
    check_status();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_status();
    reset = 1;
    run = 1;
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(i));
    do_arm(0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'(16 + i));
    check("basic count", 32'(count), 3);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    check("basic empty", 32'(empty), 1);
    do_arm(0);
    cycle(0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(1, 0, 8'(i));
    check("stop full", 32'(full), 1);
    check("stop overflow", 32'(overflow), 1);
    check("stop state", 32'(state), 3);
    check("stop head", 32'(rd_pc), 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0);
    do_arm(1);
    cycle(0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 8'(i));
    check("wrap count", 32'(count), 16);
    check("wrap overflow", 32'(overflow), 1);
    check("wrap state", 32'(state), 2);
    check("wrap head", 32'(rd_pc), 4);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0);
    do_arm(0);
    cycle(0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(32 + i));
    cycle(1, 1, 8'h55);
    check("rw count", 32'(count), 16);
    check("rw overflow", 32'(overflow), 0);
    check("rw state", 32'(state), 2);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0);
    check("rw last", 32'(rd_pc), 32'h55);
    cycle(0, 1, 0);
    do_arm(0);
    cycle(0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(1, 0, 8'(64 + i));
    run = 0;
    cycle(0, 0, 0);
    check("run drop state", 32'(state), 3);
    check("run drop count", 32'(count), 2);
    do_arm(0);
    check("rearm count", 32'(count), 0);
    check("rearm state", 32'(state), 1);
    run = 1;
    cycle(0, 0, 0);
    cycle(1, 0, 8'h77);
    reset = 0;
    arm = 1;
    @(posedge clk); #1;
    reset = 1;
    arm = 0;
    q.delete();
    m_state = 0;
    m_ovf = 0;
    check_status();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_trace_buffer.md
Name: datapath_trace_buffer

Overview:
- Parametrised on-chip trace capture unit for the processor datapath; the next generation of the processor testbench harness.
- Records one entry per retired instruction: PC, instruction word and result.
- Entries go into a DEPTH-deep circular buffer, drained through a valid/ready read port.
- Supports armed start, stop-on-full and wrap (flight-recorder) modes, plus run-gated stop and a sticky overflow flag.

Parameters:
- PC_W, 8, program counter width
- INSTR_W, 17, instruction word width
- DATA_W, 8, result width
- DEPTH, 16, buffer entries; power of two, minimum 2
- ADDR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- run  input  1  processor run enable; capture only while high
- arm  input  1  one-cycle pulse: clear buffer and arm capture
- mode  input  1  0 = stop when full, 1 = wrap/overwrite oldest; sampled on arm
- cap_valid  input  1  one instruction retires this cycle
- pc  input  PC_W  PC of retiring instruction
- instruction  input  INSTR_W  retiring instruction word
- result  input  DATA_W  writeback result
- rd_ready  input  1  consumer accepts the head entry
- rd_valid  output  1  head entry available
- rd_pc  output  PC_W  head entry PC
- rd_instr  output  INSTR_W  head entry instruction
- rd_result  output  DATA_W  head entry result
- count  output  ADDR_W+1  entries held, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a capture was dropped (mode 0) or overwrote an entry (mode 1)
- state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, write/read pointers=0, count=0, overflow=0, mode latch=0. Resulting outputs: rd_valid=0, empty=1, full=0. Memory contents are don't-care.
- Entry format: {pc, instruction, result}, PC_W+INSTR_W+DATA_W bits.
- Read data is show-ahead: rd_* = mem[rptr]. rd_valid = ~empty.
- A written entry is visible on rd_* one cycle after the capture edge.
- Read fire = rd_valid & rd_ready. It advances rptr mod DEPTH and is legal in every state.
- rd_ready while empty has no effect.
- FSM:
  - IDLE: arm -> ARMED.
  - ARMED: run==1 -> CAPTURE on the next edge; arm -> ARMED (re-clear).
  - CAPTURE: run==0 -> DONE; mode 0 with full and a dropped capture -> DONE.
  - DONE: arm -> ARMED.
- arm in any state, including CAPTURE: pointers=0, count=0, overflow=0, mode latch=mode, state=ARMED. arm has priority over capture and read in that cycle.
- Capture happens only when state==CAPTURE, run==1 and cap_valid==1. The write goes to mem[wptr], and wptr advances mod DEPTH.
- Not full: write accepted; count+1, or unchanged with a simultaneous read fire.
- Full, mode 0:
  - With a simultaneous read fire: write accepted, count stays DEPTH, no overflow.
  - Otherwise: write dropped, overflow=1, state -> DONE.
- Full, mode 1:
  - With a simultaneous read fire: normal pop+push, no overflow.
  - Otherwise: oldest entry overwritten, rptr advances with wptr, count stays DEPTH, overflow=1.
- run falling mid-capture: captures stop the same cycle (gated by run) and the FSM enters DONE next edge. Contents are retained for readout.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0 with no bubble.
- count is never greater than DEPTH and never negative.
- reset asserted mid-operation overrides everything, including arm.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, no arm, cap_valid=1 for 5 cycles -> state=0, count=0, empty=1, rd_valid=0, overflow=0.
- Basic capture and drain: arm, run=1, 3 captures with pc=0x10/0x11/0x12, result=0xA0/0xA1/0xA2, rd_ready=0 -> count=3; then rd_ready=1 -> rd_pc reads 0x10, 0x11, 0x12 in order; then empty=1.
- Stop-on-full: mode=0, DEPTH=16, 17 captures with pc=0..16 and no reads -> full=1, overflow=1, state=3 after the 17th; drained PCs read 0..15.
- Wrap mode: mode=1, 20 captures with pc=0..19 and no reads -> count=16, overflow=1, state=2; drained PCs read 4..19.
- Simultaneous full read+write: mode=0, buffer full, one cycle with cap_valid=1 and rd_ready=1 -> count stays 16, overflow=0, state=2; the new entry appears last.
- Run drop and re-arm: 2 captures, run=0 -> state=3 next edge, count=2 retained; then arm pulse -> count=0, overflow=0, state=1.
